// File: rtl/iq_alloc_ctrl.sv
// Issue-queue entry allocator: owns the free bitmap, grants up to ALLOC_W entries per cycle
// (all-or-nothing), accepts REL_W releases per cycle, tracks free count and sticky errors.
module iq_alloc_ctrl #(
   parameter int unsigned ENTRIES = 16,
   parameter int unsigned IDX_W   = 4,
   parameter int unsigned ALLOC_W = 4,
   parameter int unsigned REL_W   = 4,
   parameter int unsigned ROTATE  = 0
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic                     alloc_valid_i,
   input  logic [$clog2(ALLOC_W):0] alloc_cnt_i,
   output logic                     alloc_ready_o,
   output logic [ALLOC_W*IDX_W-1:0] alloc_idx_o,
   output logic [ALLOC_W-1:0]       alloc_idx_vld_o,
   input  logic [REL_W-1:0]         rel_vld_i,
   input  logic [REL_W*IDX_W-1:0]   rel_idx_i,
   output logic [IDX_W:0]           free_cnt_o,
   output logic                     empty_o,
   output logic                     err_o
);

   localparam int unsigned CNT_W = $clog2(ALLOC_W) + 1;
   localparam int unsigned FC_W  = IDX_W + 1;

   logic [ENTRIES-1:0] free_map_q, free_map_d;
   logic [FC_W-1:0]    free_cnt_q, free_cnt_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic               err_q, err_d;

   logic [IDX_W-1:0]   slot_idx [ALLOC_W];
   logic [ALLOC_W-1:0] slot_vld;
   logic [CNT_W-1:0]   found;
   logic [IDX_W-1:0]   pos;

   logic               fire;
   logic               alloc_bad;
   logic [ENTRIES-1:0] alloc_mask;
   logic [IDX_W-1:0]   last_idx;
   logic [ENTRIES-1:0] rel_mask;
   logic [IDX_W-1:0]   r_idx;
   logic               rel_dup;
   logic               rel_free;

   // Walk entries in search order and hand out the first ALLOC_W free ones to slots 0..ALLOC_W-1.
   always_comb begin
      slot_idx = '{default: '0};
      slot_vld = '0;
      found    = '0;
      pos      = '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
         pos = (ROTATE != 0) ? ptr_q + IDX_W'(i) : IDX_W'(i);
         if (free_map_q[pos] && (32'(found) < ALLOC_W)) begin
            for (int unsigned k = 0; k < ALLOC_W; k++) begin
               if (32'(found) == k) begin
                  slot_idx[k] = pos;
                  slot_vld[k] = 1'b1;
               end
            end
            found = found + CNT_W'(1);
         end
      end
   end

   always_comb begin
      alloc_idx_o = '0;
      for (int unsigned k = 0; k < ALLOC_W; k++) begin
         alloc_idx_o[k*IDX_W +: IDX_W] = slot_idx[k];
      end
   end

   assign alloc_idx_vld_o = slot_vld;
   assign alloc_ready_o   = ~flush_i && (32'(alloc_cnt_i) <= 32'(free_cnt_q)) &&
                            (32'(alloc_cnt_i) <= ALLOC_W);
   assign fire            = alloc_valid_i & alloc_ready_o;
   assign alloc_bad       = alloc_valid_i & (32'(alloc_cnt_i) > ALLOC_W);

   // Slots are filled in search order, so the last granted slot sets the next rotate start.
   always_comb begin
      alloc_mask = '0;
      last_idx   = '0;
      for (int unsigned k = 0; k < ALLOC_W; k++) begin
         if (fire && (k < 32'(alloc_cnt_i))) begin
            alloc_mask[slot_idx[k]] = 1'b1;
            last_idx                = slot_idx[k];
         end
      end
   end

   always_comb begin
      rel_mask = '0;
      rel_dup  = 1'b0;
      rel_free = 1'b0;
      r_idx    = '0;
      for (int unsigned p = 0; p < REL_W; p++) begin
         if (rel_vld_i[p]) begin
            r_idx = rel_idx_i[p*IDX_W +: IDX_W];
            if (rel_mask[r_idx])   rel_dup  = 1'b1;
            if (free_map_q[r_idx]) rel_free = 1'b1;
            rel_mask[r_idx] = 1'b1;
         end
      end
   end

   always_comb begin
      free_map_d = (free_map_q & ~alloc_mask) | rel_mask;
      ptr_d      = ptr_q;
      err_d      = err_q | alloc_bad;
      if (flush_i) begin
         free_map_d = '1;
         ptr_d      = '0;
      end else begin
         err_d = err_d | rel_dup | rel_free;
         if ((ROTATE != 0) && fire && (alloc_cnt_i != '0)) begin
            ptr_d = last_idx + IDX_W'(1);
         end
      end
   end

   // Count derived from the next map keeps free_cnt consistent even after erroneous releases.
   always_comb begin
      free_cnt_d = '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
         free_cnt_d = free_cnt_d + FC_W'(free_map_d[i]);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         free_map_q <= '1;
         free_cnt_q <= FC_W'(ENTRIES);
         ptr_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         free_map_q <= free_map_d;
         free_cnt_q <= free_cnt_d;
         ptr_q      <= ptr_d;
         err_q      <= err_d;
      end
   end

   assign free_cnt_o = free_cnt_q;
   assign empty_o    = (free_cnt_q == '0);
   assign err_o      = err_q;

endmodule
